// File: rtl/proteus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proteus_pkg
// Description : Shared datapath widths and helpers for the NBout writeback
//               path. Holds the default sample width, index widths and the
//               precision decode used by the packer and its rounder.
// Revision    : 1.0 - initial release
// ============================================================================
package proteus_pkg;

    localparam int BIT_WIDTH_DEF  = 16;
    localparam int BIT_IDX_DEF    = 4;
    localparam int SHIFT_BITS_DEF = 5;

    // The precision field encodes p-1 so that a full BIT_WIDTH precision fits
    // in a log2(BIT_WIDTH)-bit field.
    function automatic int unsigned prec_decode(input int unsigned n);
        return n + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nbout_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : nbout_round_sat
// Description : Combinational per-sample rounder. Drops i_offset fractional
//               bits with round-half-up, then reduces the result to a p-bit
//               signed field (p = i_n+1), returned zero-extended.
//               NBOUT_PACKER_SAT_EN defined : clamp out-of-range, flag o_sat.
//               NBOUT_PACKER_SAT_EN undefined: wrap to p bits, o_sat = 0.
// Ports       : i_in     - two's-complement sample
//               i_n      - precision minus one
//               i_offset - fractional bits to drop
//               o_field  - p-bit result in the LSBs, upper bits zero
//               o_sat    - this sample was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module nbout_round_sat
    import proteus_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int BIT_IDX   = BIT_IDX_DEF
) (
    input  logic [BIT_WIDTH-1:0] i_in,
    input  logic [BIT_IDX-1:0]   i_n,
    input  logic [BIT_IDX-1:0]   i_offset,
    output logic [BIT_WIDTH-1:0] o_field,
    output logic                 o_sat
);

    // One guard bit so the rounding increment can never overflow the sign.
    localparam int EW = BIT_WIDTH + 1;

    logic [BIT_IDX:0]       w_p;
    logic signed [EW-1:0]   w_in_ext;
    logic signed [EW-1:0]   w_shr;
    logic                   w_rbit;
    logic signed [EW-1:0]   w_r;
    logic signed [EW-1:0]   w_val;
    logic [BIT_WIDTH-1:0]   w_mask;

    assign w_p      = (BIT_IDX+1)'(prec_decode(32'(i_n)));
    assign w_in_ext = $signed({i_in[BIT_WIDTH-1], i_in});
    assign w_shr    = w_in_ext >>> i_offset;
    assign w_rbit   = (i_offset != '0) ? i_in[i_offset - 1'b1] : 1'b0;
    assign w_r      = w_shr + $signed({{(EW-1){1'b0}}, w_rbit});
    // Shifting all-ones by p=BIT_WIDTH yields zero, so the mask is all-ones.
    assign w_mask   = ~({BIT_WIDTH{1'b1}} << w_p);

`ifdef NBOUT_PACKER_SAT_EN
    logic signed [EW-1:0] w_lim;
    logic signed [EW-1:0] w_max;
    logic signed [EW-1:0] w_min;
    logic                 w_hi;
    logic                 w_lo;

    assign w_lim = $signed(EW'(1) << (w_p - 1'b1));
    assign w_max = w_lim - $signed(EW'(1));
    assign w_min = -w_lim;
    assign w_hi  = w_r > w_max;
    assign w_lo  = w_r < w_min;
    assign w_val = w_hi ? w_max : (w_lo ? w_min : w_r);
    assign o_sat = w_hi | w_lo;
`else
    assign w_val = w_r;
    assign o_sat = 1'b0;
`endif

    assign o_field = BIT_WIDTH'(w_val) & w_mask;

endmodule
`default_nettype wire

// File: rtl/nbout_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : nbout_stream_packer
// Description : Streaming NBout writeback packer. Rounds each accepted sample
//               to the packet precision, appends it LSB-first into a
//               2*BIT_WIDTH register and queues each completed word in an
//               output FIFO. i_last flushes a zero-padded partial word.
//               Optional saturation: NBOUT_PACKER_SAT_EN.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_valid/o_in_ready  - input handshake
//               i_in, i_last        - sample, end of packet
//               i_n, i_offset       - precision-1, dropped fractional bits
//               o_valid/i_ready     - output handshake
//               o_out, o_last       - packed word, final word of packet
//               o_sat               - sticky saturation flag for the packet
// Revision    : 1.0 - initial release
// ============================================================================
module nbout_stream_packer
    import proteus_pkg::*;
#(
    parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
    parameter int BIT_IDX    = BIT_IDX_DEF,
    parameter int SHIFT_BITS = SHIFT_BITS_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_in_ready,
    input  logic [BIT_WIDTH-1:0] i_in,
    input  logic                 i_last,
    input  logic [BIT_IDX-1:0]   i_n,
    input  logic [BIT_IDX-1:0]   i_offset,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BIT_WIDTH-1:0] o_out,
    output logic                 o_last,
    output logic                 o_sat
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACC_W = 2 * BIT_WIDTH;
    localparam logic [SHIFT_BITS-1:0] c_FILL_WORD = SHIFT_BITS'(BIT_WIDTH);
    // A beat can push two words, so input is held off below two free slots.
    localparam logic [CNT_W-1:0]      c_READY_MAX = CNT_W'(FIFO_DEPTH - 2);

    // Packing state; r_first marks that the next beat opens a packet.
    logic                  r_first;
    logic [BIT_IDX-1:0]    r_n;
    logic [BIT_IDX-1:0]    r_offset;
    logic [ACC_W-1:0]      r_acc;
    logic [SHIFT_BITS-1:0] r_fill;

    logic [BIT_WIDTH-1:0]  r_mem_word [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept;
    logic                  w_pop;
    logic [BIT_IDX-1:0]    w_n;
    logic [BIT_IDX-1:0]    w_offset;
    logic [SHIFT_BITS-1:0] w_p;
    logic [BIT_WIDTH-1:0]  w_field;
    logic                  w_sat;
    logic [ACC_W-1:0]      w_acc_new;
    logic [ACC_W-1:0]      w_acc_rem;
    logic [SHIFT_BITS-1:0] w_fill_new;
    logic [SHIFT_BITS-1:0] w_fill_rem;
    logic                  w_full;
    logic                  w_flush_res;
    logic [1:0]            w_push_cnt;
    logic                  w_last_a;

    assign o_in_ready = !rst && (r_count <= c_READY_MAX);
    assign w_accept   = i_valid & o_in_ready;
    assign o_valid    = !rst && (r_count != '0);
    assign w_pop      = o_valid & i_ready;
    assign o_out      = o_valid ? r_mem_word[r_rd_ptr] : '0;
    assign o_last     = o_valid ? r_mem_last[r_rd_ptr] : 1'b0;

    // The first beat of a packet uses its own config before it is latched.
    assign w_n      = r_first ? i_n      : r_n;
    assign w_offset = r_first ? i_offset : r_offset;
    assign w_p      = SHIFT_BITS'(prec_decode(32'(w_n)));

    nbout_round_sat #(
        .BIT_WIDTH (BIT_WIDTH),
        .BIT_IDX   (BIT_IDX)
    ) u_round_sat (
        .i_in     (i_in),
        .i_n      (w_n),
        .i_offset (w_offset),
        .o_field  (w_field),
        .o_sat    (w_sat)
    );

    assign w_acc_new   = r_acc | ({{BIT_WIDTH{1'b0}}, w_field} << r_fill);
    assign w_fill_new  = r_fill + w_p;
    assign w_full      = w_fill_new >= c_FILL_WORD;
    assign w_acc_rem   = w_full ? (w_acc_new >> BIT_WIDTH) : w_acc_new;
    assign w_fill_rem  = w_full ? (w_fill_new - c_FILL_WORD) : w_fill_new;
    assign w_flush_res = i_last && (w_fill_rem != '0);

    // Word A is always the low half of the updated accumulator: either the
    // completed word or, when nothing completed, the residual being flushed.
    // Word B only exists when a completed word is followed by a residual.
    always_comb begin
        w_push_cnt = 2'd0;
        w_last_a   = 1'b0;
        if (w_accept) begin
            if (w_full) begin
                w_push_cnt = w_flush_res ? 2'd2 : 2'd1;
                w_last_a   = i_last & ~w_flush_res;
            end else if (w_flush_res) begin
                w_push_cnt = 2'd1;
                w_last_a   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first  <= 1'b1;
            r_n      <= '0;
            r_offset <= '0;
            r_acc    <= '0;
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                if (r_first) begin
                    r_n      <= i_n;
                    r_offset <= i_offset;
                end
                if (i_last) begin
                    r_acc   <= '0;
                    r_fill  <= '0;
                    r_first <= 1'b1;
                end else begin
                    r_acc   <= w_acc_rem;
                    r_fill  <= w_fill_rem;
                    r_first <= 1'b0;
                end
            end
            if (w_push_cnt != 2'd0) begin
                r_mem_word[r_wr_ptr] <= w_acc_new[BIT_WIDTH-1:0];
                r_mem_last[r_wr_ptr] <= w_last_a;
            end
            if (w_push_cnt == 2'd2) begin
                r_mem_word[r_wr_ptr + PTR_W'(1)] <= w_acc_rem[BIT_WIDTH-1:0];
                r_mem_last[r_wr_ptr + PTR_W'(1)] <= 1'b1;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
        end
    end

`ifdef NBOUT_PACKER_SAT_EN
    logic r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= r_first ? w_sat : (r_sat | w_sat);
        end
    end

    assign o_sat = r_sat;
`else
    assign o_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nbout_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbout_stream_packer
// Description : Directed self-checking bench for nbout_stream_packer.
//               Expected words are hand-computed from the sample values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbout_stream_packer;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_in_ready;
    logic [15:0] i_in;
    logic        i_last;
    logic [3:0]  i_n;
    logic [3:0]  i_offset;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_out;
    logic        o_last;
    logic        o_sat;

    int          n_checks;
    int          n_fail;
    logic [16:0] r_words [$];
    logic        r_saw_not_ready;

    nbout_stream_packer u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .i_in       (i_in),
        .i_last     (i_last),
        .i_n        (i_n),
        .i_offset   (i_offset),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_out      (o_out),
        .o_last     (o_last),
        .o_sat      (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every word the DUT hands over, in order.
    always @(negedge clk) begin
        if (o_valid && i_ready) r_words.push_back({o_last, o_out});
        if (!rst && !o_in_ready) r_saw_not_ready = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic [3:0] n, input logic [3:0] off);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        i_valid = 1'b1; i_in = d; i_last = l; i_n = n; i_offset = off;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk); #1;
            t++;
        end
        i_valid = 1'b0;
        if (!acc) check_eq("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_words(input int n);
        int t;
        t = 0;
        while (r_words.size() < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("word_count", r_words.size(), n);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] w, input logic l);
        logic [16:0] e;
        if (r_words.size() == 0) begin
            check_eq({tag, "_present"}, 32'(r_words.size()), 32'd1);
        end else begin
            e = r_words.pop_front();
            check_eq({tag, "_word"}, {16'd0, e[15:0]}, {16'd0, w});
            check_eq({tag, "_last"}, {31'd0, e[16]}, {31'd0, l});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; r_saw_not_ready = 1'b0;
        rst = 1'b1; i_valid = 1'b0; i_in = '0; i_last = 1'b0;
        i_n = '0; i_offset = '0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'd0, o_valid}, 0);
        check_eq("rst_ready", {31'd0, o_in_ready}, 0);
        check_eq("rst_out", {16'd0, o_out}, 0);
        check_eq("rst_last", {31'd0, o_last}, 0);
        check_eq("rst_sat", {31'd0, o_sat}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, o_in_ready}, 1);
        @(posedge clk); #1;

        // Rounding: 0x138 / 16 = 19.5 -> 20, single-sample packet.
        send(16'h0138, 1'b1, 4'd7, 4'd4);
        @(negedge clk);
        check_eq("round_latency", {31'd0, o_valid}, 1);
        @(posedge clk); #1;
        wait_words(1);
        expect_word("round", 16'h0014, 1'b1);

        // Saturation: 2040 / 16 = 127.5 -> 128 does not fit 8-bit signed.
        send(16'h07F8, 1'b1, 4'd7, 4'd4);
        wait_words(1);
`ifdef NBOUT_PACKER_SAT_EN
        expect_word("sat", 16'h007F, 1'b1);
        check_eq("sat_flag", {31'd0, o_sat}, 1);
`else
        expect_word("wrap", 16'h0080, 1'b1);
        check_eq("sat_flag", {31'd0, o_sat}, 0);
`endif

        // Byte packing; o_sat clears on the first beat of the new packet.
        send(16'h0011, 1'b0, 4'd7, 4'd0);
        check_eq("sat_clear", {31'd0, o_sat}, 0);
        send(16'h0022, 1'b0, 4'd7, 4'd0);
        send(16'h0033, 1'b0, 4'd7, 4'd0);
        send(16'h0044, 1'b1, 4'd7, 4'd0);
        wait_words(2);
        expect_word("pack0", 16'h2211, 1'b0);
        expect_word("pack1", 16'h4433, 1'b1);

        // 5-bit fields with partial flush; later config changes are ignored.
        send(16'h0001, 1'b0, 4'd4, 4'd0);
        send(16'h0002, 1'b0, 4'd7, 4'd2);
        send(16'h0003, 1'b0, 4'd7, 4'd2);
        send(16'h0004, 1'b1, 4'd7, 4'd2);
        wait_words(2);
        expect_word("part0", 16'h0C41, 1'b0);
        expect_word("part1", 16'h0002, 1'b1);

        // Backpressure: downstream stalls while eight bytes stream in.
        r_saw_not_ready = 1'b0;
        fork
            begin
                send(16'h0011, 1'b0, 4'd7, 4'd0);
                send(16'h0022, 1'b0, 4'd7, 4'd0);
                send(16'h0033, 1'b0, 4'd7, 4'd0);
                send(16'h0044, 1'b0, 4'd7, 4'd0);
                send(16'h0055, 1'b0, 4'd7, 4'd0);
                send(16'h0066, 1'b0, 4'd7, 4'd0);
                send(16'h0077, 1'b0, 4'd7, 4'd0);
                send(16'h0088, 1'b1, 4'd7, 4'd0);
            end
            begin
                i_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        wait_words(4);
        check_eq("bp_ready_drop", {31'd0, r_saw_not_ready}, 1);
        expect_word("bp0", 16'h2211, 1'b0);
        expect_word("bp1", 16'h4433, 1'b0);
        expect_word("bp2", 16'h6655, 1'b0);
        expect_word("bp3", 16'h8877, 1'b1);

        // Reset mid-packet discards the partial word and the latched config.
        send(16'h0001, 1'b0, 4'd4, 4'd0);
        send(16'h0002, 1'b0, 4'd4, 4'd0);
        send(16'h0003, 1'b0, 4'd4, 4'd0);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rst_no_words", r_words.size(), 0);
        send(16'h00AB, 1'b0, 4'd7, 4'd0);
        send(16'h00CD, 1'b1, 4'd7, 4'd0);
        wait_words(1);
        expect_word("post_rst", 16'hCDAB, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
